volatility_stats: RTL and testbench

Per-stock rolling statistics engine that sits directly downstream of the volatility buffer write-address controller. It consumes each (write address, stock id, price) event and owns the NUM_STOCKS×BUFFER_SIZE sample RAM. For each event it reads back the sample being overwritten, then updates the per-stock running sum and sum of squares. It emits a division-free scaled variance for the pricing/quoting stage.

---
 rtl/volatility_stats_if.sv | 42 ++++
 rtl/volatility_stats.sv | 199 +++++++++++++++++++
 tb/tb_volatility_stats.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/volatility_stats_if.sv
// volatility_stats_if: event/result bundle between the write-address
// controller, the rolling statistics engine and the pricing stage.
//   master: drives i_addr_valid / i_write_address / i_stock_id / i_price,
//           observes o_ready and the result/pulse outputs.
//   slave : the statistics engine (volatility_stats).
interface volatility_stats_if #(
    parameter int unsigned NUM_STOCKS  = 4,
    parameter int unsigned BUFFER_SIZE = 20,
    parameter int unsigned DATA_WIDTH  = 32
);
    localparam int unsigned AW  = $clog2(NUM_STOCKS * BUFFER_SIZE);
    localparam int unsigned IDW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
    localparam int unsigned CW  = $clog2(BUFFER_SIZE + 1);
    localparam int unsigned SW  = DATA_WIDTH + CW;
    localparam int unsigned VW  = 2 * SW;

    logic                  i_addr_valid;
    logic [AW-1:0]         i_write_address;
    logic [IDW-1:0]        i_stock_id;
    logic [DATA_WIDTH-1:0] i_price;

    logic                  o_ready;
    logic                  o_valid;
    logic [IDW-1:0]        o_stock_id;
    logic [CW-1:0]         o_count;
    logic [SW-1:0]         o_sum;
    logic [VW-1:0]         o_var_scaled;
    logic                  o_drop;
    logic                  o_addr_err;

    modport master (
        output i_addr_valid, i_write_address, i_stock_id, i_price,
        input  o_ready, o_valid, o_stock_id, o_count, o_sum, o_var_scaled,
               o_drop, o_addr_err
    );

    modport slave (
        input  i_addr_valid, i_write_address, i_stock_id, i_price,
        output o_ready, o_valid, o_stock_id, o_count, o_sum, o_var_scaled,
               o_drop, o_addr_err
    );
endinterface

// File: rtl/volatility_stats.sv
// volatility_stats: per-stock rolling window statistics engine.
// Owns the NUM_STOCKS x BUFFER_SIZE sample RAM. Each accepted event reads
// the sample it overwrites, updates the stock's count / sum / sum of squares
// and reports o_var_scaled = N*sum(x^2) - sum(x)^2 (= N^2 * variance).
// Ports:
//   i_clk      rising-edge clock
//   i_reset_n  synchronous, active-low reset
//   bus        volatility_stats_if.slave (event inputs, o_ready, result,
//              o_drop / o_addr_err pulses); all outputs registered.
module volatility_stats #(
    parameter int unsigned NUM_STOCKS  = 4,
    parameter int unsigned BUFFER_SIZE = 20,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    volatility_stats_if.slave      bus
);
    localparam int unsigned DEPTH = NUM_STOCKS * BUFFER_SIZE;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned RW    = AW + 1;
    localparam int unsigned IDW   = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
    localparam int unsigned CW    = $clog2(BUFFER_SIZE + 1);
    localparam int unsigned SW    = DATA_WIDTH + CW;
    localparam int unsigned PW    = 2 * DATA_WIDTH;
    localparam int unsigned QW    = 2 * DATA_WIDTH + CW;
    localparam int unsigned VW    = 2 * SW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_UPDATE,
        S_CALC
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  accept_c;
    logic                  addr_err_c;

    logic [RW-1:0]         lo_c;
    logic [RW-1:0]         hi_c;
    logic [RW-1:0]         addr_ext_c;
    logic                  in_range_c;

    logic [AW-1:0]         addr_q;
    logic [IDW-1:0]        id_q;
    logic [DATA_WIDTH-1:0] price_q;
    logic [DATA_WIDTH-1:0] old_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    logic [CW-1:0]         count_r [NUM_STOCKS];
    logic [SW-1:0]         sum_r   [NUM_STOCKS];
    logic [QW-1:0]         sumsq_r [NUM_STOCKS];

    logic                  fill_c;
    logic [PW-1:0]         sq_new_c;
    logic [PW-1:0]         sq_old_c;
    logic [CW-1:0]         count_upd_c;
    logic [SW-1:0]         sum_upd_c;
    logic [QW-1:0]         sumsq_upd_c;
    logic [VW-1:0]         var_c;

    logic                  ready_q;
    logic                  valid_q;
    logic                  drop_q;
    logic                  addr_err_q;
    logic [IDW-1:0]        out_id_q;
    logic [CW-1:0]         out_count_q;
    logic [SW-1:0]         out_sum_q;
    logic [VW-1:0]         out_var_q;

    // Address must fall inside the event's own stock window, and that window
    // must exist (guards stock ids beyond NUM_STOCKS for non power-of-2 counts).
    always_comb begin
        lo_c       = RW'(bus.i_stock_id) * RW'(BUFFER_SIZE);
        hi_c       = lo_c + RW'(BUFFER_SIZE);
        addr_ext_c = RW'(bus.i_write_address);
        in_range_c = (addr_ext_c >= lo_c) && (addr_ext_c < hi_c) &&
                     (hi_c <= RW'(DEPTH));
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and accept/reject decode.
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        addr_err_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_addr_valid && ready_q) begin
                    if (in_range_c) begin
                        accept_c = 1'b1;
                        state_d  = S_READ;
                    end else begin
                        addr_err_c = 1'b1;
                    end
                end
            end
            S_READ:   state_d = S_UPDATE;
            S_UPDATE: state_d = S_CALC;
            S_CALC:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Sample RAM: registered read on accept, write in UPDATE; never cleared.
    always_ff @(posedge i_clk) begin
        if (state_q == S_UPDATE) begin
            ram[addr_q] <= price_q;
        end
        if (accept_c) begin
            rdata_q <= ram[bus.i_write_address];
        end
    end

    // Window arithmetic for the latched stock. Until the window has filled,
    // the RAM slot holds a stale sample, so the outgoing value counts as 0.
    always_comb begin
        fill_c      = count_r[id_q] < CW'(BUFFER_SIZE);
        sq_new_c    = PW'(price_q) * PW'(price_q);
        sq_old_c    = PW'(old_q) * PW'(old_q);
        count_upd_c = fill_c ? count_r[id_q] + CW'(1) : count_r[id_q];
        sum_upd_c   = sum_r[id_q] + SW'(price_q) - SW'(old_q);
        sumsq_upd_c = sumsq_r[id_q] + QW'(sq_new_c) - QW'(sq_old_c);
        var_c       = VW'(count_r[id_q]) * VW'(sumsq_r[id_q]) -
                      VW'(sum_r[id_q]) * VW'(sum_r[id_q]);
    end

    // Datapath, per-stock accumulators and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            drop_q      <= 1'b0;
            addr_err_q  <= 1'b0;
            out_id_q    <= '0;
            out_count_q <= '0;
            out_sum_q   <= '0;
            out_var_q   <= '0;
            addr_q      <= '0;
            id_q        <= '0;
            price_q     <= '0;
            old_q       <= '0;
            for (int s = 0; s < int'(NUM_STOCKS); s++) begin
                count_r[s] <= '0;
                sum_r[s]   <= '0;
                sumsq_r[s] <= '0;
            end
        end else begin
            ready_q    <= (state_d == S_IDLE);
            valid_q    <= (state_q == S_CALC);
            drop_q     <= bus.i_addr_valid && !ready_q;
            addr_err_q <= addr_err_c;

            if (accept_c) begin
                addr_q  <= bus.i_write_address;
                id_q    <= bus.i_stock_id;
                price_q <= bus.i_price;
            end

            if (state_q == S_READ) begin
                old_q <= fill_c ? '0 : rdata_q;
            end

            if (state_q == S_UPDATE) begin
                count_r[id_q] <= count_upd_c;
                sum_r[id_q]   <= sum_upd_c;
                sumsq_r[id_q] <= sumsq_upd_c;
            end

            if (state_q == S_CALC) begin
                out_id_q    <= id_q;
                out_count_q <= count_r[id_q];
                out_sum_q   <= sum_r[id_q];
                out_var_q   <= var_c;
            end
        end
    end

    assign bus.o_ready      = ready_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_drop       = drop_q;
    assign bus.o_addr_err   = addr_err_q;
    assign bus.o_stock_id   = out_id_q;
    assign bus.o_count      = out_count_q;
    assign bus.o_sum        = out_sum_q;
    assign bus.o_var_scaled = out_var_q;
endmodule

// File: tb/tb_volatility_stats.sv
// tb_volatility_stats: directed cases plus randomized events for
// volatility_stats. Expected results come from a sliding-window model
// (the last BUFFER_SIZE prices of each stock, summed directly).
module tb_volatility_stats;
    localparam int unsigned NS  = 4;
    localparam int unsigned B   = 20;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = $clog2(NS * B);
    localparam int unsigned IDW = $clog2(NS);
    localparam int unsigned CW  = $clog2(B + 1);
    localparam int unsigned SW  = DW + CW;
    localparam int unsigned VW  = 2 * SW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    volatility_stats_if #(.NUM_STOCKS(NS), .BUFFER_SIZE(B), .DATA_WIDTH(DW)) vif ();

    volatility_stats #(.NUM_STOCKS(NS), .BUFFER_SIZE(B), .DATA_WIDTH(DW)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (vif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [CW-1:0]  cnt;
        logic [SW-1:0]  sum;
        logic [VW-1:0]  v;
    } res_t;

    res_t exp_q[$];
    res_t mon_e;
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   exp_drop = 0;
    int   exp_err  = 0;

    logic [DW-1:0] win [NS][B];
    int            wcnt [NS];
    int            wptr [NS];

    function automatic void chk(string name, logic [127:0] act, logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < int'(NS); s++) begin
            wcnt[s] = 0;
            wptr[s] = 0;
        end
    endfunction

    // Append a price to the stock's window and compute the statistics afresh.
    function automatic res_t model_push(int id, logic [DW-1:0] price);
        res_t         r;
        logic [127:0] s;
        logic [127:0] q;
        logic [127:0] x;
        logic [127:0] n;
        win[id][wptr[id]] = price;
        wptr[id] = (wptr[id] + 1) % int'(B);
        if (wcnt[id] < int'(B)) wcnt[id]++;
        s = '0;
        q = '0;
        for (int i = 0; i < wcnt[id]; i++) begin
            x = 128'(win[id][i]);
            s = s + x;
            q = q + x * x;
        end
        n     = 128'(wcnt[id]);
        r.id  = IDW'(id);
        r.cnt = CW'(wcnt[id]);
        r.sum = SW'(s);
        r.v   = VW'(n * q - s * s);
        return r;
    endfunction

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (vif.o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: o_ready stayed low for 50 cycles, expected high");
        end
    endtask

    // Present one event; optionally hold i_addr_valid one extra cycle (a drop).
    task automatic drive(input int a, input int id, input logic [DW-1:0] p, input bit extra);
        wait_ready();
        vif.i_addr_valid    = 1'b1;
        vif.i_write_address = AW'(a);
        vif.i_stock_id      = IDW'(id);
        vif.i_price         = p;
        @(posedge clk);
        #1;
        if (extra) begin
            vif.i_price = ~p;
            @(posedge clk);
            #1;
        end
        vif.i_addr_valid = 1'b0;
    endtask

    task automatic send(input int id, input logic [DW-1:0] p, input bit extra);
        int a;
        a = id * int'(B) + wptr[id];
        exp_q.push_back(model_push(id, p));
        if (extra) exp_drop++;
        drive(a, id, p, extra);
    endtask

    task automatic send_bad(input int id, input int a, input logic [DW-1:0] p);
        exp_err++;
        drive(a, id, p, 1'b0);
    endtask

    // Monitor: compares every result and pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vif.o_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got o_valid=1, expected 0");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("o_stock_id", 128'(vif.o_stock_id), 128'(mon_e.id));
                    chk("o_count", 128'(vif.o_count), 128'(mon_e.cnt));
                    chk("o_sum", 128'(vif.o_sum), 128'(mon_e.sum));
                    chk("o_var_scaled", 128'(vif.o_var_scaled), 128'(mon_e.v));
                end
            end
            if (vif.o_drop) begin
                n_cmp++;
                if (exp_drop == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_drop: got o_drop=1, expected 0");
                end else begin
                    exp_drop--;
                end
            end
            if (vif.o_addr_err) begin
                n_cmp++;
                if (exp_err == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_addr_err: got o_addr_err=1, expected 0");
                end else begin
                    exp_err--;
                end
            end
        end
    end

    initial begin
        int id;
        int a;
        logic [DW-1:0] p;

        vif.i_addr_valid    = 1'b0;
        vif.i_write_address = '0;
        vif.i_stock_id      = '0;
        vif.i_price         = '0;
        model_clear();

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 128'(vif.o_ready), 0);
        chk("rst_valid", 128'(vif.o_valid), 0);
        chk("rst_drop", 128'(vif.o_drop), 0);
        chk("rst_addr_err", 128'(vif.o_addr_err), 0);
        chk("rst_stock_id", 128'(vif.o_stock_id), 0);
        chk("rst_count", 128'(vif.o_count), 0);
        chk("rst_sum", 128'(vif.o_sum), 0);
        chk("rst_var", 128'(vif.o_var_scaled), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 128'(vif.o_ready), 1);

        // Single sample on stock 0: busy for three cycles, result in the fourth.
        send(0, 32'd10, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ready_busy", 128'(vif.o_ready), 0);
            chk("valid_early", 128'(vif.o_valid), 0);
        end
        @(negedge clk);
        chk("valid_t4", 128'(vif.o_valid), 1);
        chk("ready_t4", 128'(vif.o_ready), 1);

        // Stock 2: prices 2 then 4 -> N=2, sum 6, scaled variance 4.
        send(2, 32'd2, 1'b0);
        send(2, 32'd4, 1'b0);

        // Stock 1: fill with 5s, then wrap with a 25.
        for (int k = 0; k < int'(B); k++) send(1, 32'd5, 1'b0);
        send(1, 32'd25, 1'b0);

        // Second strobe while busy is dropped and not accumulated.
        send(0, 32'd7, 1'b1);
        @(negedge clk);
        chk("drop_pulse", 128'(vif.o_drop), 1);

        // Stock 3 with an address from stock 0's window.
        send_bad(3, 5, 32'd99);
        @(negedge clk);
        chk("addr_err_pulse", 128'(vif.o_addr_err), 1);
        chk("addr_err_ready", 128'(vif.o_ready), 1);
        send(3, 32'd8, 1'b0);

        // Reset two cycles after an accept aborts the event.
        drive(int'(B) + wptr[1], 1, 32'd55, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        chk("abort_count", 128'(vif.o_count), 0);
        chk("abort_valid", 128'(vif.o_valid), 0);
        send(1, 32'd123, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            id = int'($urandom_range(0, NS - 1));
            case ($urandom_range(0, 3))
                0:       p = $urandom();
                1:       p = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: p = 32'($urandom_range(0, 200));
            endcase
            if ($urandom_range(0, 9) == 0) begin
                a = int'($urandom_range(0, (1 << AW) - 1));
                if (a / int'(B) == id && a < int'(NS * B)) a = a + int'(B);
                send_bad(id, a, p);
            end else begin
                send(id, p, $urandom_range(0, 5) == 0);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
        end

        // Drain.
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("pending_results", 128'(exp_q.size()), 0);
        chk("pending_drops", 128'(exp_drop), 0);
        chk("pending_addr_errs", 128'(exp_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
